full_adder_slice: RTL and testbench

- Ripple-carry adder slice: a WIDTH-bit chain of single-bit full adders with carry-in and carry-out.
- At WIDTH=1 it is the 1-bit cell that is chained 64 times to build the 64-bit PC/address adder.
- The sum path is purely combinational so slices can be rippled without added latency.
- A registered copy of the result, with valid tracking, is provided for pipelined use.

---
 rtl/full_adder_slice_pkg.sv | 14 +
 rtl/full_adder_slice_bit.sv | 17 +
 rtl/full_adder_slice.sv | 76 +++++++
 tb/tb_full_adder_slice.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/full_adder_slice_pkg.sv
// Shared constants and helpers for the ripple-carry adder slice.
package full_adder_slice_pkg;

    // Default slice width: a single full-adder cell.
    localparam int DEFAULT_WIDTH = 1;

    // Signed overflow of an addition.
    // The carry into the MSB differs from the carry out of the MSB exactly when
    // two same-sign operands produce a result of the opposite sign.
    function automatic logic signed_overflow(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage

// File: rtl/full_adder_slice_bit.sv
// Single-bit full adder cell, pure gate-level, chained by the slice top.
module full_adder_bit (
    input  logic A,
    input  logic B,
    input  logic carry_in,
    output logic out,
    output logic carry_out
);

    logic half_sum;

    // Propagate term is shared by the sum and the carry.
    assign half_sum  = A ^ B;
    assign out       = half_sum ^ carry_in;
    assign carry_out = (A & B) | (carry_in & half_sum);

endmodule

// File: rtl/full_adder_slice.sv
// WIDTH-bit ripple-carry adder slice.
// The sum, carry and overflow are combinational so slices can be rippled with
// no added latency. A one-cycle registered copy with valid tracking is kept
// alongside for pipelined users.
module full_adder_slice
    import full_adder_slice_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic [WIDTH-1:0] out_q,
    output logic             carry_out_q,
    output logic             overflow_q,
    output logic             out_valid
);

    // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] leaves the slice.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_bits;

    logic [WIDTH-1:0] out_q_reg;
    logic             carry_out_q_reg;
    logic             overflow_q_reg;
    logic             out_valid_reg;

    assign carry_chain[0] = carry_in;

    // One full-adder cell per bit, carry rippling from bit gi to bit gi+1.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_bit u_bit (
                .A         (A[gi]),
                .B         (B[gi]),
                .carry_in  (carry_chain[gi]),
                .out       (sum_bits[gi]),
                .carry_out (carry_chain[gi+1])
            );
        end
    endgenerate

    assign out       = sum_bits;
    assign carry_out = carry_chain[WIDTH];
    // At WIDTH=1 this compares carry_in against the cell's carry out.
    assign overflow  = signed_overflow(carry_chain[WIDTH-1], carry_chain[WIDTH]);

    // Registered copy: valid follows in_valid every edge, data loads only when valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q_reg       <= '0;
            carry_out_q_reg <= 1'b0;
            overflow_q_reg  <= 1'b0;
            out_valid_reg   <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_q_reg       <= sum_bits;
                carry_out_q_reg <= carry_chain[WIDTH];
                overflow_q_reg  <= overflow;
            end
        end
    end

    assign out_q       = out_q_reg;
    assign carry_out_q = carry_out_q_reg;
    assign overflow_q  = overflow_q_reg;
    assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_full_adder_slice.sv
// Directed bench for full_adder_slice at WIDTH=1 and WIDTH=64.
module tb_full_adder_slice;

    logic        clk;
    logic        reset;
    logic        in_valid;

    // WIDTH=1 instance
    logic        a1, b1, cin1;
    logic        out1, co1, ov1, out_q1, co_q1, ov_q1, vld1;

    // WIDTH=64 instance
    logic [63:0] a64, b64;
    logic        cin64;
    logic [63:0] out64, out_q64;
    logic        co64, ov64, co_q64, ov_q64, vld64;

    int checks;
    int failures;

    full_adder_slice #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .A           (a1),
        .B           (b1),
        .carry_in    (cin1),
        .in_valid    (in_valid),
        .out         (out1),
        .carry_out   (co1),
        .overflow    (ov1),
        .out_q       (out_q1),
        .carry_out_q (co_q1),
        .overflow_q  (ov_q1),
        .out_valid   (vld1)
    );

    full_adder_slice #(.WIDTH(64)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .A           (a64),
        .B           (b64),
        .carry_in    (cin64),
        .in_valid    (in_valid),
        .out         (out64),
        .carry_out   (co64),
        .overflow    (ov64),
        .out_q       (out_q64),
        .carry_out_q (co_q64),
        .overflow_q  (ov_q64),
        .out_valid   (vld64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply a 64-bit combinational vector and check sum, carry and overflow.
    task automatic vec64(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic [63:0] exp_out,
                         input logic exp_co, input logic exp_ov);
        a64 = a; b64 = b; cin64 = cin;
        #1;
        $display("vec64 %s A=%h B=%h cin=%0d -> out=%h co=%0d ov=%0d", tag, a, b, cin, out64, co64, ov64);
        check({tag, ".out"}, {1'b0, out64}, {1'b0, exp_out});
        check({tag, ".co"}, {64'd0, co64}, {64'd0, exp_co});
        check({tag, ".ov"}, {64'd0, ov64}, {64'd0, exp_ov});
    endtask

    initial begin
        logic [1:0] exp_sum1;
        logic       exp_ov1;
        checks = 0; failures = 0;
        reset = 1'b0; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a64 = '0; b64 = '0; cin64 = 1'b0;

        // Async reset assertion between edges
        #2 reset = 1'b1;
        #1;
        $display("reset asserted: out_q64=%h vld64=%0d vld1=%0d", out_q64, vld64, vld1);
        check("rst.out_q64", {1'b0, out_q64}, 65'd0);
        check("rst.co_q64", {64'd0, co_q64}, 65'd0);
        check("rst.ov_q64", {64'd0, ov_q64}, 65'd0);
        check("rst.vld64", {64'd0, vld64}, 65'd0);
        check("rst.vld1", {64'd0, vld1}, 65'd0);
        @(negedge clk);
        reset = 1'b0;

        // WIDTH=1 exhaustive sweep; overflow from the same-sign/different-result rule
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; cin1 = i[0];
            #1;
            exp_sum1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
            exp_ov1  = (a1 == b1) && (exp_sum1[0] != a1);
            $display("vec1 A=%0d B=%0d cin=%0d -> out=%0d co=%0d ov=%0d", a1, b1, cin1, out1, co1, ov1);
            check($sformatf("w1_%0d.sum", i), {63'd0, co1, out1}, {63'd0, exp_sum1});
            check($sformatf("w1_%0d.ov", i), {64'd0, ov1}, {64'd0, exp_ov1});
        end
        // Hand spot checks from the table
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; #1;
        check("w1_111", {63'd0, co1, out1}, 65'd3);
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; #1;
        check("w1_100", {63'd0, co1, out1}, 65'd1);

        // WIDTH=64 directed vectors
        vec64("zero",   64'd0,    64'd0,    1'b0, 64'd0,    1'b0, 1'b0);
        vec64("one",    64'd0,    64'd1,    1'b0, 64'd1,    1'b0, 1'b0);
        vec64("s1656",  64'd456,  64'd1200, 1'b0, 64'd1656, 1'b0, 1'b0);
        vec64("s2469",  64'd2340, 64'd129,  1'b0, 64'd2469, 1'b0, 1'b0);
        vec64("s1351",  64'd349,  64'd1002, 1'b0, 64'd1351, 1'b0, 1'b0);
        vec64("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        vec64("cin_rip", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b0);
        vec64("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        vec64("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1);
        vec64("m1m1",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        vec64("cin5",   64'd2, 64'd2, 1'b1, 64'd5, 1'b0, 1'b0);

        // Registered path: capture 456+1200, and 1+1+1 on the 1-bit slice
        @(negedge clk);
        a64 = 64'd456; b64 = 64'd1200; cin64 = 1'b0; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk); #1;
        $display("capture: out_q64=%0d vld64=%0d out_q1=%0d co_q1=%0d", out_q64, vld64, out_q1, co_q1);
        check("reg.out_q64", {1'b0, out_q64}, 65'd1656);
        check("reg.vld64", {64'd0, vld64}, 65'd1);
        check("reg.co_q64", {64'd0, co_q64}, 65'd0);
        check("reg.w1", {62'd0, ov_q1, co_q1, out_q1}, {62'd0, 3'b011});

        // Hold when in_valid=0
        @(negedge clk);
        a64 = 64'd1; b64 = 64'd1; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(posedge clk); #1;
        $display("hold: out_q64=%0d vld64=%0d out64=%0d", out_q64, vld64, out64);
        check("hold.out_q64", {1'b0, out_q64}, 65'd1656);
        check("hold.vld64", {64'd0, vld64}, 65'd0);
        check("hold.out_q1", {63'd0, co_q1, out_q1}, 65'd3);

        // Capture an overflowing sum so every register is nonzero
        @(negedge clk);
        a64 = 64'h8000_0000_0000_0000; b64 = 64'h8000_0000_0000_0001; in_valid = 1'b1;
        @(posedge clk); #1;
        $display("ovf capture: out_q64=%h co_q64=%0d ov_q64=%0d", out_q64, co_q64, ov_q64);
        check("ovfq.out_q64", {1'b0, out_q64}, 65'd1);
        check("ovfq.flags", {63'd0, co_q64, ov_q64}, 65'd3);

        // Async reset between edges: immediate clear, combinational path still live
        @(negedge clk);
        in_valid = 1'b0;
        a64 = 64'd2340; b64 = 64'd129;
        #2 reset = 1'b1;
        #1;
        $display("mid reset: out_q64=%h co_q64=%0d ov_q64=%0d vld64=%0d out64=%0d",
                 out_q64, co_q64, ov_q64, vld64, out64);
        check("mrst.out_q64", {1'b0, out_q64}, 65'd0);
        check("mrst.flags", {62'd0, co_q64, ov_q64, vld64}, 65'd0);
        check("mrst.out64", {1'b0, out64}, 65'd2469);
        check("mrst.w1", {61'd0, out_q1, co_q1, ov_q1, vld1}, 65'd0);

        // Capture attempted while reset held is discarded
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("hrst.out_q64", {1'b0, out_q64}, 65'd0);
        check("hrst.vld64", {64'd0, vld64}, 65'd0);

        // First edge after release captures
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        $display("post reset: out_q64=%0d vld64=%0d", out_q64, vld64);
        check("rel.out_q64", {1'b0, out_q64}, 65'd2469);
        check("rel.vld64", {64'd0, vld64}, 65'd1);

        // Back-to-back captures
        @(negedge clk);
        a64 = 64'd349; b64 = 64'd1002;
        @(posedge clk); #1;
        check("b2b.out_q64", {1'b0, out_q64}, 65'd1351);
        check("b2b.vld64", {64'd0, vld64}, 65'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
